axi4lite_reg_bank: RTL

- AXI4-lite slave register bank that terminates the sub-bus driven by the upstream cheby AXI4-lite bridge's `sub_*` master port.
- Provides N_REGS read/write 32-bit registers with byte strobes, plus one read-only status word.
- Unmapped accesses return SLVERR.
- At most one outstanding write and one outstanding read; the read and write paths are independent.

---
 rtl/axi4lite_reg_bank_if.sv | 39 +++
 rtl/axi4lite_reg_bank.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_bank_if.sv
// AXI4-lite bus bundle between an upstream master (bridge sub_* port) and the
// register bank. clk/reset are not part of the bundle.
//   master modport: drives AW/W/AR payload+valid and B/R ready
//   slave  modport: drives AW/W/AR ready and B/R response
interface axi4lite_reg_bank_if #(
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4lite_reg_bank.sv
// AXI4-lite slave register bank: N_REGS byte-strobed RW registers at word
// indices 0..N_REGS-1, a read-only status word at index N_REGS, SLVERR for
// everything else. One outstanding write and one outstanding read, on
// independent paths.
// Ports:
//   aclk, areset  clock and asynchronous active-high reset
//   s_axi         AXI4-lite slave bundle (AW/W/B/AR/R)
//   status_i      read-only status word
//   regs_o        RW register contents, register i at [32i+31:32i]
//   wr_pulse_o    one-cycle strobe per register after each OKAY write
module axi4lite_reg_bank #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned N_REGS      = 4,
    parameter logic [31:0] RESET_VALUE = 32'h00000000
) (
    input  logic                   aclk,
    input  logic                   areset,
    axi4lite_reg_bank_if.slave     s_axi,
    input  logic [31:0]            status_i,
    output logic [32*N_REGS-1:0]   regs_o,
    output logic [N_REGS-1:0]      wr_pulse_o
);
    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(N_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0]       regs_q [N_REGS];
    logic              aw_held;
    logic              w_held;
    logic              ar_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [IDX_W-1:0]  ar_idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic [N_REGS-1:0] wr_pulse_q;
    logic [31:0]       rd_data_c;
    logic [1:0]        rd_resp_c;

    // Ready is a pure function of the held flags: no input-to-output path.
    assign s_axi.awready = ~aw_held;
    assign s_axi.wready  = ~w_held;
    assign s_axi.arready = ~ar_held;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign wr_pulse_o    = wr_pulse_q;

    for (genvar g = 0; g < int'(N_REGS); g++) begin : g_regs_o
        assign regs_o[32*g +: 32] = regs_q[g];
    end

    // Protection bits and byte offset within the word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Write path: capture AW and W independently, execute once both are held.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < int'(N_REGS); i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            wr_pulse_q <= '0;
            if (s_axi.awvalid && !aw_held) begin
                aw_idx_q <= s_axi.awaddr[ADDR_WIDTH-1:2];
                aw_held  <= 1'b1;
            end
            if (s_axi.wvalid && !w_held) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
                w_held  <= 1'b1;
            end
            if (aw_held && w_held && !bvalid_q) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (aw_idx_q < STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < int'(N_REGS); i++) begin
                    if (aw_idx_q == IDX_W'(i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) begin
                                regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                        wr_pulse_q[i] <= 1'b1;
                    end
                end
            end else if (bvalid_q && s_axi.bready) begin
                // Held flags stay set through the response so no new AW/W is
                // taken until the following cycle.
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    // Read source mux; sampled at the load edge so a coincident write is not seen.
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_SLVERR;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (ar_idx_q == IDX_W'(i)) begin
                rd_data_c = regs_q[i];
                rd_resp_c = RESP_OKAY;
            end
        end
        if (ar_idx_q == STATUS_IDX) begin
            rd_data_c = status_i;
            rd_resp_c = RESP_OKAY;
        end
    end

    // Read path: one-cycle latency from AR handshake to rvalid.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ar_held  <= 1'b0;
            ar_idx_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (s_axi.arvalid && !ar_held) begin
                ar_idx_q <= s_axi.araddr[ADDR_WIDTH-1:2];
                ar_held  <= 1'b1;
            end
            if (ar_held && !rvalid_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_c;
                rresp_q  <= rd_resp_c;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
                ar_held  <= 1'b0;
            end
        end
    end
endmodule
